// File: rtl/display_scan_scheduler.sv
// display_scan_scheduler
// Multiplexed seven-segment scanner. Each digit slot is split into a guard
// (ghost-blanking) interval, a brightness-controlled on-time and an off-time.
// number, dp_mask and brightness are snapshotted once per frame so that every
// digit of a frame comes from the same data.
// Optional feature: define LEADING_ZERO_BLANK_EN to keep leading zero digits dark.
// GUARD_CYCLES is expected to be at least 1 and below the slot length.

module display_scan_scheduler #(
    parameter int NUMBER_OF_DIGITS            = 4,
    parameter int REFRESH_RATE_IN_HERTZ       = 500,
    parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
    parameter int GUARD_CYCLES                = 64
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                enable,
    input  logic [4*NUMBER_OF_DIGITS-1:0]       number,
    input  logic [NUMBER_OF_DIGITS-1:0]         dp_mask,
    input  logic [3:0]                          brightness,
    output logic [NUMBER_OF_DIGITS-1:0]         io_sel,
    output logic [7:0]                          io_seg,
    output logic [$clog2(NUMBER_OF_DIGITS)-1:0] digit_idx,
    output logic                                frame_start
);

    localparam int N           = NUMBER_OF_DIGITS;
    localparam int SLOT_CYCLES = BOARD_CLOCK_FREQUENCY_IN_HZ / REFRESH_RATE_IN_HERTZ / NUMBER_OF_DIGITS;
    localparam int ACTIVE      = SLOT_CYCLES - GUARD_CYCLES;
    localparam int CNT_W       = $clog2(SLOT_CYCLES);
    localparam int IDX_W       = $clog2(NUMBER_OF_DIGITS);

    localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_GUARD_END = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(N - 1);
    localparam logic [31:0]      ACTIVE_W      = 32'(ACTIVE);
    localparam logic [31:0]      GUARD_W       = 32'(GUARD_CYCLES);

    typedef enum logic [1:0] {
        GUARD,
        ON,
        OFF
    } scan_state_t;

    scan_state_t      state;
    logic [CNT_W-1:0] slot_cnt;

    logic [4*N-1:0]   number_q;
    logic [N-1:0]     dp_q;
    logic [3:0]       brightness_q;

    logic             slot_wrap;
    logic             frame_first;
    logic [3:0]       view_brightness;
    logic [31:0]      on_product;
    logic [31:0]      on_cycles;
    logic [31:0]      on_last;
    logic             on_done;

    logic [3:0]       cur_digit;
    logic             cur_dp;
    logic             cur_blank;
    logic [N-1:0]     sel_onehot;
    logic [N-1:0]     blank_vec;

    // Active-low segment pattern (g..a) for a BCD code; codes above 9 are blank.
    function automatic logic [6:0] seg_pattern(input logic [3:0] code);
        logic [6:0] lit;
        case (code)
            4'd0:    lit = 7'h3F;
            4'd1:    lit = 7'h06;
            4'd2:    lit = 7'h5B;
            4'd3:    lit = 7'h4F;
            4'd4:    lit = 7'h66;
            4'd5:    lit = 7'h6D;
            4'd6:    lit = 7'h7D;
            4'd7:    lit = 7'h07;
            4'd8:    lit = 7'h7F;
            4'd9:    lit = 7'h6F;
            default: lit = 7'h00;
        endcase
        return ~lit;
    endfunction

    assign slot_wrap   = (slot_cnt == CNT_LAST);
    assign frame_first = (slot_cnt == '0) && (digit_idx == '0);

    // On-time from brightness; on the latch cycle the incoming value is used so
    // that the slot timing always follows the data of the frame being shown.
    always_comb begin
        view_brightness = frame_first ? brightness : brightness_q;
        on_product      = ACTIVE_W * (32'(view_brightness) + 32'd1);
        on_cycles       = on_product >> 4;
        if (on_cycles == 32'd0) begin
            on_cycles = 32'd1;
        end
        on_last = GUARD_W + on_cycles - 32'd1;
        on_done = (32'(slot_cnt) == on_last);
    end

    // Snapshot the display data on the first counter cycle of digit 0's slot;
    // the new data becomes visible together with the frame_start pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            number_q     <= '0;
            dp_q         <= '0;
            brightness_q <= '0;
        end else if (frame_first) begin
            number_q     <= number;
            dp_q         <= dp_mask;
            brightness_q <= brightness;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [N-1:1] zero_run;

    // A digit is dark when it and every digit above it are zero, unless it is
    // digit 0 or carries a decimal point.
    always_comb begin
        zero_run  = '0;
        blank_vec = '0;
        zero_run[N-1] = (number_q[4*(N-1) +: 4] == 4'd0);
        for (int i = N - 2; i >= 1; i--) begin
            zero_run[i] = zero_run[i+1] && (number_q[4*i +: 4] == 4'd0);
        end
        for (int i = 1; i < N; i++) begin
            blank_vec[i] = zero_run[i] && !dp_q[i];
        end
    end
`else
    assign blank_vec = '0;
`endif

    // Pick the data, decimal point and blanking flag of the current slot.
    always_comb begin
        cur_digit  = 4'd0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        sel_onehot = '0;
        for (int i = 0; i < N; i++) begin
            if (digit_idx == IDX_W'(i)) begin
                cur_digit     = number_q[4*i +: 4];
                cur_dp        = dp_q[i];
                cur_blank     = blank_vec[i];
                sel_onehot[i] = 1'b1;
            end
        end
    end

    // Slot counter, digit index, guard/on/off sequencing and registered pins;
    // the pins follow the state of the previous cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= GUARD;
            slot_cnt    <= '0;
            digit_idx   <= '0;
            frame_start <= 1'b0;
            io_sel      <= '1;
            io_seg      <= 8'hFF;
        end else begin
            slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
            if (slot_wrap) begin
                digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
            end
            frame_start <= frame_first;

            case (state)
                GUARD: begin
                    if (slot_cnt == CNT_GUARD_END) begin
                        state <= ON;
                    end
                end
                ON: begin
                    if (on_done) begin
                        state <= slot_wrap ? GUARD : OFF;
                    end else if (slot_wrap) begin
                        state <= GUARD;
                    end
                end
                OFF: begin
                    if (slot_wrap) begin
                        state <= GUARD;
                    end
                end
                default: state <= GUARD;
            endcase

            if (enable && (state == ON) && !cur_blank) begin
                io_sel <= ~sel_onehot;
                io_seg <= {~cur_dp, seg_pattern(cur_digit)};
            end else begin
                io_sel <= '1;
                io_seg <= 8'hFF;
            end
        end
    end

endmodule
